// File: rtl/sft_led_drv_pkg.sv
// Shared definitions for the 74HC595 LED chain driver:
// FSM state encoding and default frame geometry.
package sft_led_drv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DEF_DW      = 8;
    localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/sft_led_drv_oe_pwm.sv
// Output-enable brightness generator for the 74HC595 chain.
// Only compiled and used when SFT_LED_OE_PWM_EN is defined.
`ifdef SFT_LED_OE_PWM_EN
module sft_oe_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pwm_duty,
    output logic       sft_oe_n
);

    logic [7:0] cnt;

    // Free-running 8-bit ramp; outputs are enabled (active low) while ramp < duty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 8'd0;
            sft_oe_n <= 1'b1;
        end else begin
            cnt      <= cnt + 8'd1;
            sft_oe_n <= !(cnt < pwm_duty);
        end
    end

endmodule
`endif

// File: rtl/sft_led_drv.sv
// Serial driver for a 74HC595 LED shift-register chain.
// Shifts DW bits MSB first on sft_shcp, then pulses sft_stcp to latch.
// A single pending buffer lets a request made mid-frame follow back-to-back.
// Optional feature: define SFT_LED_OE_PWM_EN to add pwm_duty/sft_oe_n
// brightness control through the sft_oe_pwm sub-module.
module sft_led_drv
    import sft_led_drv_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld,
    input  logic [DW-1:0] din,
    output logic          busy,
    output logic          done,
    output logic          sft_shcp,
    output logic          sft_ds,
    output logic          sft_stcp
`ifdef SFT_LED_OE_PWM_EN
    ,
    input  logic [7:0]    pwm_duty,
    output logic          sft_oe_n
`endif
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DW + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DW - 1);

    state_t        state;
    logic [DW-1:0] shreg;
    logic [DW-1:0] shreg_next;
    logic [DW-1:0] pend_buf;
    logic [DW-1:0] next_frame;
    logic          pend;
    logic [PW-1:0] phase;
    logic [BW-1:0] bitcnt;
    logic          phase_end;

    assign phase_end  = (phase == PHASE_LAST);
    assign shreg_next = shreg << 1;
    // A request arriving in the LATCH-exit cycle is newer than the buffer
    assign next_frame = vld ? din : pend_buf;

    // Frame sequencer: all chain-facing outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            pend_buf <= '0;
            pend     <= 1'b0;
            phase    <= '0;
            bitcnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sft_shcp <= 1'b0;
            sft_ds   <= 1'b0;
            sft_stcp <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && vld) begin
                pend     <= 1'b1;
                pend_buf <= din;
            end
            case (state)
                IDLE: begin
                    if (vld) begin
                        state    <= SHIFT_LO;
                        shreg    <= din;
                        sft_ds   <= din[DW-1];
                        sft_shcp <= 1'b0;
                        phase    <= '0;
                        bitcnt   <= '0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        phase    <= '0;
                        sft_shcp <= 1'b1;
                        state    <= SHIFT_HI;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        phase    <= '0;
                        sft_shcp <= 1'b0;
                        shreg    <= shreg_next;
                        bitcnt   <= bitcnt + 1'b1;
                        if (bitcnt == BIT_LAST) begin
                            state    <= LATCH;
                            sft_stcp <= 1'b1;
                        end else begin
                            state  <= SHIFT_LO;
                            sft_ds <= shreg_next[DW-1];
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        phase    <= '0;
                        sft_stcp <= 1'b0;
                        done     <= 1'b1;
                        if (vld || pend) begin
                            state  <= SHIFT_LO;
                            shreg  <= next_frame;
                            sft_ds <= next_frame[DW-1];
                            bitcnt <= '0;
                            pend   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SFT_LED_OE_PWM_EN
    sft_oe_pwm u_oe_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_duty (pwm_duty),
        .sft_oe_n (sft_oe_n)
    );
`endif

endmodule

// File: tb/tb_sft_led_drv.sv
// Testbench for sft_led_drv: an 8-bit / divide-by-4 instance driven by
// directed tables, corner sequences and random requests against a
// frame-level reference model, plus a 1-bit / divide-by-1 instance.
`timescale 1ns/1ps
module tb_sft_led_drv;

    localparam int DW        = 8;
    localparam int CD        = 4;
    localparam int SHIFT_LEN = 2 * DW * CD;
    localparam int FRAME_LEN = SHIFT_LEN + CD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld   = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       busy, done, sft_shcp, sft_ds, sft_stcp;

    logic       vld1 = 1'b0;
    logic [0:0] din1 = 1'b0;
    logic       busy1, done1, shcp1, ds1, stcp1;

`ifdef SFT_LED_OE_PWM_EN
    logic [7:0] pwm_duty  = 8'd0;
    logic [7:0] pwm_duty1 = 8'd0;
    logic       sft_oe_n, oe_n1;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sft_led_drv #(.DW(DW), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .sft_shcp (sft_shcp),
        .sft_ds   (sft_ds),
        .sft_stcp (sft_stcp)
`ifdef SFT_LED_OE_PWM_EN
        ,
        .pwm_duty (pwm_duty),
        .sft_oe_n (sft_oe_n)
`endif
    );

    sft_led_drv #(.DW(1), .CLK_DIV(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld1),
        .din      (din1),
        .busy     (busy1),
        .done     (done1),
        .sft_shcp (shcp1),
        .sft_ds   (ds1),
        .sft_stcp (stcp1)
`ifdef SFT_LED_OE_PWM_EN
        ,
        .pwm_duty (pwm_duty1),
        .sft_oe_n (oe_n1)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            if (err_cnt <= 40)
                $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds vld high across exactly one rising edge; call just after an edge
    task automatic apply_stimulus(input logic [7:0] d);
        vld = 1'b1;
        din = d;
        @(posedge clk);
        #1 vld = 1'b0;
    endtask

    // Frame-level model: remaining busy cycles, current frame, one pending slot
    int         m_rem  = 0;
    logic       m_pend = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_pbuf = 8'h00;
    logic [7:0] m_cur  = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_pend = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (vld) begin
                    m_rem = FRAME_LEN;
                    m_cur = din;
                end
            end else begin
                if (vld) begin
                    m_pend = 1'b1;
                    m_pbuf = din;
                end
                if (m_rem == 1) begin
                    m_done = 1'b1;
                    if (m_pend) begin
                        m_rem  = FRAME_LEN;
                        m_cur  = m_pbuf;
                        m_pend = 1'b0;
                    end else begin
                        m_rem = 0;
                    end
                end else begin
                    m_rem--;
                end
            end
        end
    end

    // Behaves like the external 74HC595: shift on shcp rise, latch on stcp rise
    logic [7:0] mon_sr = 8'h00;
    logic [7:0] latch_log[$];
    always @(posedge sft_shcp) mon_sr = {mon_sr[6:0], sft_ds};
    always @(posedge sft_stcp) latch_log.push_back(mon_sr);

    // Per-cycle comparison against the model, plus done / busy-drop tallies
    int   done_cnt  = 0;
    int   busy_fall = 0;
    logic prev_busy = 1'b0;
    int   pos;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (prev_busy && !busy) busy_fall++;
            prev_busy = busy;
            check_output("busy", busy, m_rem > 0);
            check_output("done", done, m_done);
            if (m_rem == 0) begin
                check_output("shcp_idle", sft_shcp, 1'b0);
                check_output("stcp_idle", sft_stcp, 1'b0);
            end else begin
                pos = FRAME_LEN - m_rem;
                if (pos < SHIFT_LEN) begin
                    check_output("shcp", sft_shcp, (pos % (2 * CD)) >= CD);
                    check_output("stcp", sft_stcp, 1'b0);
                    check_output("ds", sft_ds, m_cur[DW - 1 - pos / (2 * CD)]);
                end else begin
                    check_output("shcp_latch", sft_shcp, 1'b0);
                    check_output("stcp_latch", sft_stcp, 1'b1);
                    if (pos == SHIFT_LEN)
                        check_output("latched", (latch_log.size() > 0) ? latch_log[$] : 8'hxx, m_cur);
                end
            end
        end else begin
            prev_busy = 1'b0;
        end
    end

    // Wait (bounded) for the driver to go idle, then let tallies settle
    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        check_output("idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] d, output int lat, output int stcp_hi,
                             output int rises, output logic [7:0] latched);
        int   n0;
        logic prev_s;
        n0 = latch_log.size();
        @(posedge clk);
        #1 apply_stimulus(d);
        lat     = 0;
        stcp_hi = 0;
        rises   = 0;
        prev_s  = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (sft_stcp) stcp_hi++;
            if (sft_shcp && !prev_s) rises++;
            prev_s = sft_shcp;
            if (done) break;
        end
        latched = (latch_log.size() > n0) ? latch_log[$] : 8'hxx;
    endtask

    typedef struct {
        logic [7:0] din;
        int         lead;
        logic [7:0] exp_latch;
        int         exp_lat;
        int         exp_stcp;
        int         exp_rises;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int         lat, stcp_hi, rises, n0, d0, b0;
        int         c_busy, c_shcp, c_stcp, c_done, c_low;
        logic [7:0] latched;

        tbl[0] = '{din: 8'hA5, lead: 0, exp_latch: 8'hA5, exp_lat: 68, exp_stcp: 4, exp_rises: 8};
        tbl[1] = '{din: 8'h00, lead: 3, exp_latch: 8'h00, exp_lat: 68, exp_stcp: 4, exp_rises: 8};
        tbl[2] = '{din: 8'hFF, lead: 1, exp_latch: 8'hFF, exp_lat: 68, exp_stcp: 4, exp_rises: 8};
        tbl[3] = '{din: 8'h96, lead: 5, exp_latch: 8'h96, exp_lat: 68, exp_stcp: 4, exp_rises: 8};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_shcp", sft_shcp, 1'b0);
        check_output("rst_ds", sft_ds, 1'b0);
        check_output("rst_stcp", sft_stcp, 1'b0);
        check_output("rst_busy1", busy1, 1'b0);
`ifdef SFT_LED_OE_PWM_EN
        check_output("rst_oe_n", sft_oe_n, 1'b1);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed single frames
        for (int i = 0; i < 4; i++) begin
            repeat (tbl[i].lead) @(posedge clk);
            run_frame(tbl[i].din, lat, stcp_hi, rises, latched);
            check_output("tbl_done_latency", lat, tbl[i].exp_lat);
            check_output("tbl_stcp_len", stcp_hi, tbl[i].exp_stcp);
            check_output("tbl_shcp_rises", rises, tbl[i].exp_rises);
            check_output("tbl_latched", latched, tbl[i].exp_latch);
            wait_idle(20);
        end

        // Mid-frame requests coalesce: last one wins
        n0 = latch_log.size();
        d0 = done_cnt;
        b0 = busy_fall;
        @(posedge clk);
        #1 apply_stimulus(8'h01);
        repeat (10) @(posedge clk);
        #1 apply_stimulus(8'h0F);
        repeat (5) @(posedge clk);
        #1 apply_stimulus(8'hF0);
        wait_idle(300);
        check_output("coal_frames", latch_log.size() - n0, 2);
        check_output("coal_first", (latch_log.size() > n0) ? latch_log[n0] : 8'hxx, 8'h01);
        check_output("coal_second", (latch_log.size() > n0 + 1) ? latch_log[n0 + 1] : 8'hxx, 8'hF0);
        check_output("coal_dones", done_cnt - d0, 2);
        check_output("coal_busy_drops", busy_fall - b0, 1);

        // Request landing exactly on the LATCH-exit edge
        n0 = latch_log.size();
        d0 = done_cnt;
        b0 = busy_fall;
        @(posedge clk);
        #1 apply_stimulus(8'h81);
        repeat (FRAME_LEN - 1) @(posedge clk);
        #1 apply_stimulus(8'h3C);
        wait_idle(300);
        check_output("bnd_frames", latch_log.size() - n0, 2);
        check_output("bnd_second", (latch_log.size() > n0 + 1) ? latch_log[n0 + 1] : 8'hxx, 8'h3C);
        check_output("bnd_dones", done_cnt - d0, 2);
        check_output("bnd_busy_drops", busy_fall - b0, 1);

        // Reset in the middle of bit 3 aborts the frame silently
        n0 = latch_log.size();
        d0 = done_cnt;
        @(posedge clk);
        #1 apply_stimulus(8'hC3);
        repeat (3 * 2 * CD) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", busy, 1'b0);
        check_output("mid_rst_done", done, 1'b0);
        check_output("mid_rst_shcp", sft_shcp, 1'b0);
        check_output("mid_rst_ds", sft_ds, 1'b0);
        check_output("mid_rst_stcp", sft_stcp, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        check_output("mid_rst_no_latch", latch_log.size() - n0, 0);
        check_output("mid_rst_no_done", done_cnt - d0, 0);
        run_frame(8'hFF, lat, stcp_hi, rises, latched);
        check_output("post_rst_latency", lat, 68);
        check_output("post_rst_latched", latched, 8'hFF);
        check_output("post_rst_stcp_len", stcp_hi, 4);
        wait_idle(20);

        // Random request traffic against the model
        repeat (1500) begin
            @(posedge clk);
            #1;
            vld = ($urandom_range(0, 24) == 0);
            din = 8'($urandom);
        end
        vld = 1'b0;
        wait_idle(300);

        // Smallest geometry: one bit, divide by one
        c_busy = 0;
        c_shcp = 0;
        c_stcp = 0;
        c_done = 0;
        @(posedge clk);
        #1 vld1 = 1'b1;
        din1 = 1'b1;
        @(posedge clk);
        #1 vld1 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy1) c_busy++;
            if (stcp1) c_stcp++;
            if (done1) c_done++;
            if (shcp1) begin
                c_shcp++;
                check_output("dw1_ds", ds1, 1'b1);
            end
        end
        check_output("dw1_busy_len", c_busy, 3);
        check_output("dw1_shcp_len", c_shcp, 1);
        check_output("dw1_stcp_len", c_stcp, 1);
        check_output("dw1_done_cnt", c_done, 1);

`ifdef SFT_LED_OE_PWM_EN
        // Output-enable duty cycle
        pwm_duty = 8'd64;
        repeat (3) @(posedge clk);
        c_low = 0;
        repeat (256) begin
            @(negedge clk);
            if (!sft_oe_n) c_low++;
        end
        check_output("pwm64_low", c_low, 64);
        pwm_duty = 8'd0;
        repeat (3) @(posedge clk);
        c_low = 0;
        repeat (256) begin
            @(negedge clk);
            if (!sft_oe_n) c_low++;
        end
        check_output("pwm0_low", c_low, 0);
`else
        c_low = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
